cordic_angle_mag: RTL and testbench
===================================

// Module: cordic_angle_mag
// PURPOSE
//  Sits directly downstream of the conjugate-multiply discriminator.
//  Converts each complex product {imag[31:16], real[15:0]} into a phase angle and a magnitude.
//  Uses an iterative vectoring CORDIC.
//  The angle is the instantaneous-frequency sample fed to the audio decimation path.
//  AXI-Stream in, AXI-Stream out. One sample is in flight at a time.
// PARAMETERS
//  C_S00_AXIS_TDATA_WIDTH  32  input tdata width; only 32 is supported
//  C_M00_AXIS_TDATA_WIDTH  32  output tdata width; only 32 is supported
//  NUM_ITER                16  CORDIC micro-rotations, legal range 1..16
// PORTS
//  s00_axis_aclk     in   1   sole clock
//  s00_axis_aresetn  in   1   asynchronous active-low reset
//  s00_axis_tvalid   in   1   input sample valid
//  s00_axis_tdata    in   32  [15:0] real x, [31:16] imag y, both signed two's complement
//  s00_axis_tstrb    in   4   byte strobes, passed through
//  s00_axis_tlast    in   1   frame end, passed through
//  s00_axis_tready   out  1   block can accept a sample
//  m00_axis_tready   in   1   downstream ready
//  m00_axis_tvalid   out  1   result valid
//  m00_axis_tdata    out  32  [15:0] magnitude (unsigned), [31:16] angle (signed binary angle)
//  m00_axis_tstrb    out  4   strobe of the sample that produced this result
//  m00_axis_tlast    out  1   tlast of the sample that produced this result
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE.
//   - m00_axis_tvalid/tdata/tstrb/tlast all 0.
//   - Internal x, y, z and iteration counter all 0.
//   - s00_axis_tready reads 1 once reset is released.
//  FSM IDLE -> ITER -> OUT -> IDLE.
//   - s00_axis_tready = (state==IDLE).
//   - m00_axis_tvalid = 1 only in OUT.
//  IDLE, on tvalid&&tready:
//   - Latch tstrb and tlast.
//   - Sign-extend x and y to 18 bits.
//   - Pre-rotate: if x<0, x=-x and y=-y; z0 = (y_in>=0) ? 16'h8000 : 16'h8000. The two values are equal because +pi and -pi alias at 0x8000.
//   - Otherwise z0=0.
//   - zero_flag = (x_in==0 && y_in==0).
//   - Counter i=0. Go to ITER.
//  ITER, one micro-rotation per clock:
//   - If y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
//   - Else: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
//   - Both updates use the old x and y values.
//   - After the iteration with i==NUM_ITER-1, go to OUT.
//  Arithmetic:
//   - x and y are 18-bit signed; no overflow is possible (max |x| about 76.3k).
//   - z is 16-bit modular binary angle: 65536 = 2*pi, 0x4000 = +pi/2, 0x8000 = -pi.
//   - Wrap-around of z is intended.
//  ATAN[0..15] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
//  OUT:
//   - tdata = {z, x[16:1]}, so magnitude is about 0.8234*|v|. CORDIC gain is not compensated.
//   - If zero_flag is set, tdata = 0.
//   - tdata/tstrb/tlast are registered and held stable while tvalid=1 && tready=0.
//   - On tvalid&&tready: go to IDLE and drop tvalid.
//  Timing:
//   - Latency: m00_axis_tvalid rises on the NUM_ITER+1-th rising edge after the accepting edge.
//   - Throughput: one sample per NUM_ITER+3 cycles with no backpressure.
//  Boundary conditions:
//   - Input is ignored outside IDLE; tready=0 there, so there is no overrun.
//   - Reset asserted in ITER/OUT: tvalid drops immediately and the sample is discarded. No partial output follows release.
//   - Input (-32768,-32768) must not overflow.
// TESTING
//  - (x=16384, y=0) -> angle 0 +/-4, magnitude 13491 +/-4. tvalid 17 edges after accept.
//  - (0,16384) -> angle 16384 +/-4. (0,-16384) -> angle -16384 +/-4. Magnitude 13491 +/-4 for both.
//  - (-16384,0) -> angle 0x8000 +/-4 (modular). (-32768,-32768) -> angle -24576 +/-4, magnitude 38157 +/-8.
//  - (0,0) -> tdata 32'h00000000. tstrb=4'hF and tlast=1 are passed through.
//  - Hold m00_axis_tready=0 for 10 cycles in OUT -> tdata stable, s00_axis_tready=0. Next sample is accepted only after the output handshake.
//  - Pulse aresetn low mid-ITER -> m00_axis_tvalid=0 at once. s00_axis_tready=1 after release. No stale output appears.

Source files
------------

// File: rtl/cordic_angle_mag.sv
`default_nettype none
// ============================================================================
// Module      : cordic_angle_mag
// Description : Iterative vectoring CORDIC. Converts a complex discriminator
//               product {imag, real} into a signed binary angle and an
//               (uncompensated) magnitude. AXI-Stream in and out, one sample
//               in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_angle_mag #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,  // only 32 is supported
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,  // only 32 is supported
  parameter int NUM_ITER               = 16   // micro-rotations, 1..16
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast
);

  localparam logic [3:0]  LAST_ITER = 4'(NUM_ITER - 1);
  localparam logic [15:0] ANGLE_PI  = 16'h8000;  // +pi and -pi alias here

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                                  state_q, state_d;
  logic signed [17:0]                      x_q, x_d;
  logic signed [17:0]                      y_q, y_d;
  logic        [15:0]                      z_q, z_d;
  logic        [3:0]                       iter_q, iter_d;
  logic                                    zero_q, zero_d;
  logic        [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] strb_q, strb_d;
  logic                                    last_q, last_d;
  logic        [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                                    tvalid_q, tvalid_d;

  logic signed [17:0] x_in;
  logic signed [17:0] y_in;
  logic signed [17:0] x_sh;
  logic signed [17:0] y_sh;
  logic        [15:0] atan_i;

  // atan(2^-i) in binary-angle units (65536 = 2*pi)
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'd8192;
      4'd1:    return 16'd4836;
      4'd2:    return 16'd2555;
      4'd3:    return 16'd1297;
      4'd4:    return 16'd651;
      4'd5:    return 16'd326;
      4'd6:    return 16'd163;
      4'd7:    return 16'd81;
      4'd8:    return 16'd41;
      4'd9:    return 16'd20;
      4'd10:   return 16'd10;
      4'd11:   return 16'd5;
      4'd12:   return 16'd3;
      4'd13:   return 16'd1;
      4'd14:   return 16'd1;
      default: return 16'd0;
    endcase
  endfunction

  // Operand preparation: sign-extended inputs and the current shifted terms
  assign x_in   = {{2{s00_axis_tdata[15]}}, s00_axis_tdata[15:0]};
  assign y_in   = {{2{s00_axis_tdata[31]}}, s00_axis_tdata[31:16]};
  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign atan_i = atan_lut(iter_q);

  // Next-state and datapath: accept, rotate NUM_ITER times, then present result
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    iter_d   = iter_q;
    zero_d   = zero_q;
    strb_d   = strb_q;
    last_d   = last_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;

    case (state_q)
      IDLE: begin
        if (s00_axis_tvalid) begin
          strb_d = s00_axis_tstrb;
          last_d = s00_axis_tlast;
          zero_d = (x_in == 18'sd0) && (y_in == 18'sd0);
          iter_d = 4'd0;
          // Fold the left half-plane onto the right so the vectoring
          // iterations only need to cover +/-pi/2.
          if (x_in[17]) begin
            x_d = -x_in;
            y_d = -y_in;
            z_d = ANGLE_PI;
          end else begin
            x_d = x_in;
            y_d = y_in;
            z_d = 16'd0;
          end
          state_d = ITER;
        end
      end

      ITER: begin
        // Drive y toward zero; both updates use the pre-rotation x and y
        if (!y_q[17]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        if (iter_q == LAST_ITER) begin
          state_d = OUT;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end

      OUT: begin
        // First OUT cycle loads the output register; it then holds until taken
        if (!tvalid_q) begin
          tvalid_d = 1'b1;
          tdata_d  = zero_q ? '0 : {z_q, x_q[16:1]};
        end else if (m00_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any sample in flight
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter_q   <= '0;
      zero_q   <= 1'b0;
      strb_q   <= '0;
      last_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      iter_q   <= iter_d;
      zero_q   <= zero_d;
      strb_q   <= strb_d;
      last_q   <= last_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign s00_axis_tready = (state_q == IDLE);
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = strb_q;
  assign m00_axis_tlast  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_angle_mag.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_angle_mag
// Description : Self-checking bench for cordic_angle_mag. Results are compared
//               against an ideal atan2/sqrt reference scaled by the CORDIC gain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_angle_mag;

  localparam int  NUM_ITER  = 16;
  localparam real PI        = 3.14159265358979323846;
  localparam real HALF_GAIN = 0.8233801;  // CORDIC gain (1.6467602) / 2

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data  = '0;
  logic [3:0]  s_strb  = '0;
  logic        s_last  = 1'b0;
  logic        s_ready;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic        m_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_angle_mag #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .NUM_ITER(NUM_ITER)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid (s_valid),
    .s00_axis_tdata  (s_data),
    .s00_axis_tstrb  (s_strb),
    .s00_axis_tlast  (s_last),
    .s00_axis_tready (s_ready),
    .m00_axis_tready (m_ready),
    .m00_axis_tvalid (m_valid),
    .m00_axis_tdata  (m_data),
    .m00_axis_tstrb  (m_strb),
    .m00_axis_tlast  (m_last)
  );

  // Single comparison point; wrap16 compares modulo 2^16 (binary angles)
  task automatic check(input string tag, input int got, input int exp,
                       input int tol, input bit wrap16);
    int          diff;
    logic [15:0] dw;
    checks++;
    if (wrap16) begin
      dw   = 16'(got - exp);
      diff = int'($signed(dw));
    end else begin
      diff = got - exp;
    end
    if (diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Ideal reference: angle in 65536-per-turn units, magnitude with CORDIC gain
  task automatic model(input int x, input int y, output int ang, output int mag);
    real a;
    real m;
    a   = $atan2(real'(y), real'(x)) * 32768.0 / PI;
    ang = int'(a) & 65535;
    m   = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * HALF_GAIN;
    mag = int'(m);
  endtask

  task automatic send(input int x, input int y, input logic [3:0] strb, input logic last);
    int n;
    bit rdy;
    n       = 0;
    s_data  = {16'(y), 16'(x)};
    s_strb  = strb;
    s_last  = last;
    s_valid = 1'b1;
    do begin
      rdy = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 200);
    s_valid = 1'b0;
    if (!rdy) check("accept_timeout", 0, 1, 0, 0);
  endtask

  task automatic recv(input int stall, output logic [31:0] data, output logic [3:0] strb,
                      output logic last, output int lat);
    int n;
    n       = 0;
    m_ready = 1'b0;
    while (!m_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    lat  = n;
    data = m_data;
    strb = m_strb;
    last = m_last;
    if (!m_valid) begin
      check("output_timeout", 0, 1, 0, 0);
      return;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    if (stall > 0) begin
      check("hold_tdata", int'(m_data), int'(data), 0, 0);
      check("hold_tvalid", int'(m_valid), 1, 0, 0);
      check("hold_s_ready", int'(s_ready), 0, 0, 0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("tvalid_drop", int'(m_valid), 0, 0, 0);
    check("ready_after_hs", int'(s_ready), 1, 0, 0);
  endtask

  task automatic run_one(input int x, input int y, input logic [3:0] strb, input logic last,
                         input int stall, input int tol_a, input int tol_m);
    logic [31:0] d;
    logic [3:0]  st;
    logic        la;
    int          lat;
    int          ea;
    int          em;
    send(x, y, strb, last);
    recv(stall, d, st, la, lat);
    check("latency", lat, NUM_ITER + 1, 0, 0);
    if (x == 0 && y == 0) begin
      check("zero_tdata", int'(d), 0, 0, 0);
    end else begin
      model(x, y, ea, em);
      check("angle", int'(d[31:16]), ea, tol_a, 1'b1);
      check("mag", int'(d[15:0]), em, tol_m, 1'b0);
    end
    check("tstrb", int'(st), int'(strb), 0, 0);
    check("tlast", int'(la), int'(last), 0, 0);
  endtask

  // Back-to-back samples with no backpressure: accept spacing
  task automatic throughput();
    int acc[$];
    m_ready = 1'b1;
    s_data  = {16'd100, 16'd20000};
    s_strb  = 4'h3;
    s_last  = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (s_valid && s_ready) acc.push_back(c);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (acc.size() >= 3) begin
      check("tput_gap0", acc[1] - acc[0], NUM_ITER + 3, 0, 0);
      check("tput_gap1", acc[2] - acc[1], NUM_ITER + 3, 0, 0);
    end else begin
      check("tput_count", acc.size(), 3, 0, 0);
    end
    repeat (30) begin
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
  endtask

  // Reset while a sample is iterating and while a result is waiting
  task automatic reset_cases();
    int n;
    int stray;
    send(1000, 2000, 4'h1, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_iter_tvalid", int'(m_valid), 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_iter_s_ready", int'(s_ready), 1, 0, 0);
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (m_valid) stray++;
    end
    check("rst_iter_no_stale", stray, 0, 0, 0);

    send(-5000, 7000, 4'h8, 1'b0);
    n = 0;
    while (!m_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_out_reached", int'(m_valid), 1, 0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_out_tvalid", int'(m_valid), 0, 0, 0);
    check("rst_out_tdata", int'(m_data), 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_s_ready", int'(s_ready), 1, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rx;
    int          ry;
    logic [15:0] r16;
    longint      m2;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", int'(m_valid), 0, 0, 0);
    check("rst_tdata", int'(m_data), 0, 0, 0);
    check("rst_tstrb", int'(m_strb), 0, 0, 0);
    check("rst_tlast", int'(m_last), 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_s_ready", int'(s_ready), 1, 0, 0);

    // Directed points: axes, left half-plane, most negative corner, zero
    run_one( 16384,      0, 4'hA, 1'b0, 0, 4, 4);
    run_one(     0,  16384, 4'h5, 1'b1, 0, 4, 4);
    run_one(     0, -16384, 4'hC, 1'b0, 0, 4, 4);
    run_one(-16384,      0, 4'h3, 1'b1, 0, 4, 4);
    run_one(-32768, -32768, 4'h7, 1'b0, 0, 4, 8);
    run_one(     0,      0, 4'hF, 1'b1, 0, 4, 4);

    // Output held under backpressure
    run_one( 12000, -9000, 4'h9, 1'b1, 10, 8, 8);

    throughput();
    reset_cases();

    // Random vectors of magnitude >= 16384 with random backpressure
    for (int k = 0; k < 25; k++) begin
      do begin
        r16 = 16'($urandom);
        rx  = int'($signed(r16));
        r16 = 16'($urandom);
        ry  = int'($signed(r16));
        m2  = longint'(rx) * rx + longint'(ry) * ry;
      end while (m2 < 64'sd268435456);
      run_one(rx, ry, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 24, 24);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
